// File: rtl/instr_step_ctrl_pkg.sv
// Shared encodings and default widths for the run/step/halt controller.
package instr_step_ctrl_pkg;

    localparam int PC_W_DEF  = 32;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_HALTED = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10
    } state_e;

endpackage

// File: rtl/instr_step_ctrl_instr_counter.sv
// Retired-instruction counter: increments on each enable and wraps modulo 2^CNT_W.
module instr_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/instr_step_ctrl.sv
// Run/step/halt controller gating the stage sequencer at instruction boundaries,
// with a PC breakpoint and a retired-instruction counter.
module instr_step_ctrl
    import instr_step_ctrl_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic             done_tick,
    input  logic [PC_W-1:0]  pc,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    output logic             seq_en,
    output logic             halted,
    output logic             step_done,
    output logic             bp_hit,
    output logic [CNT_W-1:0] instr_count
);

    state_e state, state_nxt;
    logic   halt_pend, halt_pend_nxt;
    logic   bp_hit_nxt, step_done_nxt;
    logic   tick, bpm;

    // A done_tick only counts while the sequencer is actually enabled.
    assign tick = done_tick & seq_en;
    assign bpm  = bp_en & (pc == bp_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HALTED;
            seq_en    <= 1'b0;
            halted    <= 1'b1;
            step_done <= 1'b0;
            bp_hit    <= 1'b0;
            halt_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            seq_en    <= (state_nxt != ST_HALTED);
            halted    <= (state_nxt == ST_HALTED);
            step_done <= step_done_nxt;
            bp_hit    <= bp_hit_nxt;
            halt_pend <= halt_pend_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        halt_pend_nxt = halt_pend;
        bp_hit_nxt    = bp_hit;
        step_done_nxt = 1'b0;
        case (state)
            ST_HALTED: begin
                halt_pend_nxt = 1'b0;
                if (step_req) begin
                    state_nxt  = ST_STEP;
                    bp_hit_nxt = 1'b0;
                end else if (run_req) begin
                    state_nxt  = ST_RUN;
                    bp_hit_nxt = 1'b0;
                end
            end
            ST_RUN: begin
                // Stops only land on a tick so an instruction is never cut short.
                if (tick && (halt_pend || halt_req || bpm)) begin
                    state_nxt     = ST_HALTED;
                    halt_pend_nxt = 1'b0;
                    bp_hit_nxt    = bpm;
                end else if (halt_req) begin
                    halt_pend_nxt = 1'b1;
                end
            end
            ST_STEP: begin
                if (tick) begin
                    state_nxt     = ST_HALTED;
                    step_done_nxt = 1'b1;
                    bp_hit_nxt    = bpm;
                end
            end
            default: begin
                state_nxt     = ST_HALTED;
                halt_pend_nxt = 1'b0;
            end
        endcase
    end

    instr_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick),
        .count (instr_count)
    );

endmodule

// File: tb/tb_instr_step_ctrl.sv
// Vector/scoreboard bench for instr_step_ctrl; a 16-bit and a 4-bit counter
// instance share stimulus so wrap behaviour is visible on the narrow one.
module tb_instr_step_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run_req, step_req, halt_req, done_tick, bp_en;
    logic [31:0] pc, bp_addr;
    logic        seq_en, halted, step_done, bp_hit;
    logic [15:0] instr_count;
    logic        seq_en4, halted4, step_done4, bp_hit4;
    logic [3:0]  instr_count4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_step_ctrl #(.PC_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .run_req(run_req), .step_req(step_req),
        .halt_req(halt_req), .done_tick(done_tick), .pc(pc), .bp_en(bp_en),
        .bp_addr(bp_addr), .seq_en(seq_en), .halted(halted),
        .step_done(step_done), .bp_hit(bp_hit), .instr_count(instr_count)
    );

    instr_step_ctrl #(.PC_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .run_req(run_req), .step_req(step_req),
        .halt_req(halt_req), .done_tick(done_tick), .pc(pc), .bp_en(bp_en),
        .bp_addr(bp_addr), .seq_en(seq_en4), .halted(halted4),
        .step_done(step_done4), .bp_hit(bp_hit4), .instr_count(instr_count4)
    );

    typedef struct {
        bit          run, step, halt, done;
        logic [31:0] pc;
        bit          be;
        bit          e_seq, e_hlt, e_sd, e_bp;
        int          e_cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(bit r, bit s, bit h, bit d, logic [31:0] p, bit be,
                                bit es, bit eh, bit esd, bit ebp, int ec);
        vec_t v;
        v.run = r; v.step = s; v.halt = h; v.done = d; v.pc = p; v.be = be;
        v.e_seq = es; v.e_hlt = eh; v.e_sd = esd; v.e_bp = ebp; v.e_cnt = ec;
        return v;
    endfunction

    task automatic cmp(string name, int idx, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s [vec %0d]: got %0h, expected %0h", name, idx, got, exp);
        end
    endtask

    task automatic check_outputs(int idx, bit es, bit eh, bit esd, bit ebp, int ec);
        logic [31:0] ec_w;
        ec_w = ec;
        cmp("seq_en", idx, {31'b0, seq_en}, {31'b0, es});
        cmp("halted", idx, {31'b0, halted}, {31'b0, eh});
        cmp("step_done", idx, {31'b0, step_done}, {31'b0, esd});
        cmp("bp_hit", idx, {31'b0, bp_hit}, {31'b0, ebp});
        cmp("instr_count", idx, {16'b0, instr_count}, {16'b0, ec_w[15:0]});
        cmp("instr_count4", idx, {28'b0, instr_count4}, {28'b0, ec_w[3:0]});
    endtask

    task automatic apply(int idx, vec_t v);
        vec_t e;
        @(negedge clk);
        run_req = v.run; step_req = v.step; halt_req = v.halt;
        done_tick = v.done; pc = v.pc; bp_en = v.be;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_outputs(idx, e.e_seq, e.e_hlt, e.e_sd, e.e_bp, e.e_cnt);
    endtask

    initial begin
        rst_n = 1'b0;
        run_req = 0; step_req = 0; halt_req = 0; done_tick = 1; pc = '0;
        bp_en = 0; bp_addr = 32'h10;

        // Idle halted: done_tick and halt_req must be ignored.
        for (int i = 0; i < 20; i++)
            tbl.push_back(mk(0, 0, (i % 3 == 0), (i % 2 == 0), 32'h0, 0, 0, 1, 0, 0, 0));
        // Single step, tick three cycles later.
        tbl.push_back(mk(0, 1, 0, 0, 32'h0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h4, 0, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 1, 0, 0, 1));
        // Free run, five ticks, then pending halt honoured at the next tick.
        tbl.push_back(mk(1, 0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 1));
        for (int k = 0; k < 5; k++) begin
            tbl.push_back(mk(0, 0, 0, 1, 32'h100 + 4 * k, 0, 1, 0, 0, 0, 2 + k));
            tbl.push_back(mk(k == 2, k == 1, 0, 0, 32'h0, 0, 1, 0, 0, 0, 2 + k));
        end
        tbl.push_back(mk(0, 0, 1, 0, 32'h0, 0, 1, 0, 0, 0, 6));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 6));
        tbl.push_back(mk(0, 0, 0, 1, 32'h20, 0, 0, 1, 0, 0, 7));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0, 0, 0, 1, 0, 0, 7));
        // Breakpoint at 0x10, then resume past it.
        tbl.push_back(mk(1, 0, 0, 0, 32'h0, 1, 1, 0, 0, 0, 7));
        tbl.push_back(mk(0, 0, 0, 1, 32'h8, 1, 1, 0, 0, 0, 8));
        tbl.push_back(mk(0, 0, 0, 1, 32'hC, 1, 1, 0, 0, 0, 9));
        tbl.push_back(mk(0, 0, 0, 1, 32'h10, 1, 0, 1, 0, 1, 10));
        tbl.push_back(mk(0, 0, 0, 0, 32'h10, 1, 0, 1, 0, 1, 10));
        tbl.push_back(mk(1, 0, 0, 0, 32'h10, 1, 1, 0, 0, 0, 10));
        tbl.push_back(mk(0, 0, 0, 1, 32'h14, 1, 1, 0, 0, 0, 11));
        // halt_req on the same cycle as a tick stops immediately.
        tbl.push_back(mk(0, 0, 1, 1, 32'h18, 1, 0, 1, 0, 0, 12));
        // Step onto the breakpoint.
        tbl.push_back(mk(0, 1, 0, 0, 32'h0, 1, 1, 0, 0, 0, 12));
        tbl.push_back(mk(0, 0, 0, 1, 32'h10, 1, 0, 1, 1, 1, 13));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0, 1, 0, 1, 0, 1, 13));
        // run+step together chooses STEP; halt_req inside STEP is harmless.
        tbl.push_back(mk(1, 1, 0, 0, 32'h0, 1, 1, 0, 0, 0, 13));
        tbl.push_back(mk(0, 0, 1, 1, 32'h1C, 1, 0, 1, 1, 0, 14));
        // halt_req while halted must not leave a pending halt behind.
        tbl.push_back(mk(0, 0, 1, 0, 32'h0, 0, 0, 1, 0, 0, 14));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 14));
        tbl.push_back(mk(0, 0, 0, 1, 32'h10, 0, 1, 0, 0, 0, 15));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0, 0, 1, 0, 0, 0, 15));
        tbl.push_back(mk(0, 0, 0, 1, 32'h24, 0, 0, 1, 0, 0, 16));
        // 17 back-to-back ticks: narrow counter wraps.
        tbl.push_back(mk(1, 0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 16));
        for (int k = 0; k < 17; k++)
            tbl.push_back(mk(0, 0, 0, 1, 32'h200 + 4 * k, 0, 1, 0, 0, 0, 17 + k));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 33));

        // Reset state, held with done_tick high.
        repeat (3) @(posedge clk);
        #1;
        check_outputs(-1, 0, 1, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_tick = 0;

        foreach (tbl[i]) apply(i, tbl[i]);

        cmp("wrap_count4", -2, {28'b0, instr_count4}, 32'h1);

        // Asynchronous reset mid-RUN, checked before any further clock edge.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs(-3, 0, 1, 0, 0, 0);
        #2;
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
